// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Start/busy/done handshake; D/Bout/Ovf are registered and held between operations.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             a_bit, b_bit, dbit, borrow_nxt;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    d_d      = d_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    a_bit      = a_q[0];
    b_bit      = b_q[0];
    dbit       = a_bit ^ b_bit ^ borrow_q;
    borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
          cnt_d    = '0;
          res_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        res_d    = {dbit, res_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CW'(1);
        // Results are loaded on the final bit so they are already valid while done is high.
        if (cnt_q == LAST) begin
          d_d     = {dbit, res_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
          ovf_d   = (a_msb_q != b_msb_q) && (dbit != a_msb_q);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       Bin;
  logic [7:0] D;
  logic       Bout, Ovf, busy, done;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .Ovf(Ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One pulse of start, then cycle-by-cycle check of busy/done and the final result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    A = a; B = b; Bin = bin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) tick();
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done"}, 32'(done), (k == 9) ? 32'd1 : 32'd0);
    end
    check({tag, "_D"},    32'(D),    32'(ed));
    check({tag, "_Bout"}, 32'(Bout), 32'(eb));
    check({tag, "_Ovf"},  32'(Ovf),  32'(eo));
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int         npulse;
    int         pulse_cyc[$];
    logic [7:0] dcap;
    logic       bcap, ocap;

    rst = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_D",    32'(D),    32'h0);
    check("reset_Bout", 32'(Bout), 32'd0);
    check("reset_Ovf",  32'(Ovf),  32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(8'h77, 8'h35, 1'b0, 8'h42, 1'b0, 1'b0, "basic");

    // Asynchronous reset mid-cycle clears a non-zero D without a clock edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_D",    32'(D),    32'h0);
    check("async_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "zero_minus_one");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "min_minus_one");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff_ff_bin");

    // Second start during busy must be ignored.
    A = 8'hA5; B = 8'hD2; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    npulse = 0; dcap = '0; bcap = 1'b0; ocap = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) tick();
      if (k == 3) begin
        A = 8'h11; B = 8'h22; start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        npulse++;
        dcap = D; bcap = Bout; ocap = Ovf;
        check("busy_start_done_cycle", 32'(k), 32'd9);
      end
    end
    check("busy_start_pulses", 32'(npulse), 32'd1);
    check("busy_start_D",      32'(dcap),   32'hD3);
    check("busy_start_Bout",   32'(bcap),   32'd1);
    check("busy_start_Ovf",    32'(ocap),   32'd0);
    check("busy_start_idle",   32'(busy),   32'd0);

    // Reset in the middle of an operation aborts it.
    A = 8'hFF; B = 8'hC1; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_D",    32'(D),    32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) npulse++;
    end
    check("midrst_no_done", 32'(npulse), 32'd0);
    check("midrst_D_held",  32'(D),      32'h0);

    run_op(8'hDC, 8'h6A, 1'b0, 8'h72, 1'b0, 1'b1, "after_rst");

    // start held high: repeated operations every WIDTH+2 cycles.
    A = 8'h77; B = 8'h35; Bin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (done) begin
        pulse_cyc.push_back(k);
        check("b2b_D_at_done", 32'(D), 32'h42);
      end
      if (pulse_cyc.size() > 0) check("b2b_D_stable", 32'(D), 32'h42);
    end
    start = 1'b0;
    check("b2b_pulse_count", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() >= 3) begin
      check("b2b_first",    32'(pulse_cyc[0]),                32'd9);
      check("b2b_spacing1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd10);
      check("b2b_spacing2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
